// File: rtl/ram_2port_pkg.sv
// Shared definitions for the 2-port block RAM test path: default geometry,
// read-checker FSM encoding, counter width and a saturating-increment helper.
package ram_2port_pkg;

    localparam int RAM_ADDR_W = 6;
    localparam int RAM_DATA_W = 8;
    localparam int DEPTH      = 2 ** RAM_ADDR_W;
    localparam int CNT_W      = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } rd_state_e;

    // Increment that sticks at all-ones instead of wrapping back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == {CNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

endpackage

// File: rtl/rd_lat_pipe.sv
// Delay line that carries {valid, addr} of each port-B read request for LAT
// cycles, so the returning doutb can be matched to the address that produced it.
module rd_lat_pipe #(
    parameter int LAT    = 1,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_addr,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_addr
);

    logic [LAT-1:0]    valid_q;
    logic [LAT-1:0]    valid_d;
    logic [ADDR_W-1:0] addr_q [LAT];
    logic [ADDR_W-1:0] addr_d [LAT];

    // Next-stage values: stage 0 takes the request, later stages shift forward.
    always_comb begin
        valid_d[0] = in_valid;
        addr_d[0]  = in_addr;
        for (int k = 1; k < LAT; k++) begin
            valid_d[k] = valid_q[k-1];
            addr_d[k]  = addr_q[k-1];
        end
    end

    // Stage registers; reset drops every in-flight request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= {LAT{1'b0}};
            for (int k = 0; k < LAT; k++) begin
                addr_q[k] <= {ADDR_W{1'b0}};
            end
        end else begin
            valid_q <= valid_d;
            for (int k = 0; k < LAT; k++) begin
                addr_q[k] <= addr_d[k];
            end
        end
    end

    assign out_valid = valid_q[LAT-1];
    assign out_addr  = addr_q[LAT-1];

endmodule

// File: rtl/ram_rd_chk.sv
// Port-B read sequencer and data checker. A rising edge of the writer's
// "buffer full" flag starts one sweep over every address; returning data is
// compared with addr + DATA_SEED and the result is published when the sweep ends.
module ram_rd_chk
    import ram_2port_pkg::*;
#(
    parameter int ADDR_W     = RAM_ADDR_W,
    parameter int DATA_W     = RAM_DATA_W,
    parameter int RD_LATENCY = 1,
    parameter int DATA_SEED  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_flag,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic              rd_done,
    output logic              busy,
    output logic [15:0]       err_cnt,
    output logic              chk_pass,
    output logic              chk_fail,
    output logic              overrun
);

    localparam logic [ADDR_W-1:0] LAST_ADDR  = {ADDR_W{1'b1}};
    localparam logic [1:0]        DRAIN_LAST = 2'(RD_LATENCY - 1);

    rd_state_e         state_q;
    rd_state_e         state_d;
    logic              flag_q;
    logic              flag_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic [1:0]        drain_q;
    logic [1:0]        drain_d;
    logic [CNT_W-1:0]  work_q;
    logic [CNT_W-1:0]  work_d;
    logic [CNT_W-1:0]  err_cnt_q;
    logic [CNT_W-1:0]  err_cnt_d;
    logic              pass_q;
    logic              pass_d;
    logic              fail_q;
    logic              fail_d;
    logic              ovr_q;
    logic              ovr_d;

    logic              flag_edge;
    logic              pipe_valid;
    logic [ADDR_W-1:0] pipe_addr;
    logic [DATA_W-1:0] exp_data;
    logic              mismatch;

    // Request side is fully decoded from registered state.
    assign ram_rd_en   = (state_q == ST_READ);
    assign ram_rd_addr = addr_q;
    assign rd_done     = (state_q == ST_DONE);
    assign busy        = (state_q != ST_IDLE);
    assign err_cnt     = err_cnt_q;
    assign chk_pass    = pass_q;
    assign chk_fail    = fail_q;
    assign overrun     = ovr_q;

    rd_lat_pipe #(
        .LAT    (RD_LATENCY),
        .ADDR_W (ADDR_W)
    ) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (ram_rd_en),
        .in_addr   (addr_q),
        .out_valid (pipe_valid),
        .out_addr  (pipe_addr)
    );

    // Edge detect on the writer level and data comparison on the aligned word.
    always_comb begin
        flag_d    = rd_flag;
        flag_edge = rd_flag & ~flag_q;
        // Address is zero-extended or truncated to the data width before the seed add.
        exp_data  = DATA_W'(pipe_addr) + DATA_W'(DATA_SEED);
        mismatch  = pipe_valid & (ram_rd_data != exp_data);
    end

    // Sweep FSM, address counter, drain timer, working error count and status.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        drain_d   = drain_q;
        err_cnt_d = err_cnt_q;
        pass_d    = pass_q;
        fail_d    = fail_q;
        // An edge seen outside IDLE is dropped but remembered.
        ovr_d     = ovr_q | (flag_edge & (state_q != ST_IDLE));
        if (mismatch) begin
            work_d = sat_inc(work_q);
        end else begin
            work_d = work_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (flag_edge) begin
                    state_d = ST_READ;
                    addr_d  = {ADDR_W{1'b0}};
                    work_d  = {CNT_W{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                if (addr_q == LAST_ADDR) begin
                    // Park the address at 0 so nothing wraps into a second pass.
                    state_d = ST_DRAIN;
                    addr_d  = {ADDR_W{1'b0}};
                    drain_d = 2'd0;
                end else begin
                    addr_d  = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                end
            end
            ST_DRAIN: begin
                // Wait out the RAM latency so the final word reaches the comparator.
                if (drain_q == DRAIN_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    drain_d = drain_q + 2'd1;
                end
            end
            ST_DONE: begin
                // work_d already folds in any compare landing in this cycle.
                state_d   = ST_IDLE;
                err_cnt_d = work_d;
                pass_d    = (work_d == {CNT_W{1'b0}});
                fail_d    = fail_q | (work_d != {CNT_W{1'b0}});
            end
            default: begin
                state_d = ST_IDLE;
                addr_d  = {ADDR_W{1'b0}};
            end
        endcase
    end

    // State and status registers; reset aborts any sweep and clears all results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            flag_q    <= 1'b0;
            addr_q    <= {ADDR_W{1'b0}};
            drain_q   <= 2'd0;
            work_q    <= {CNT_W{1'b0}};
            err_cnt_q <= {CNT_W{1'b0}};
            pass_q    <= 1'b0;
            fail_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            flag_q    <= flag_d;
            addr_q    <= addr_d;
            drain_q   <= drain_d;
            work_q    <= work_d;
            err_cnt_q <= err_cnt_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
            ovr_q     <= ovr_d;
        end
    end

endmodule
